// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the cardinal NIC processor-side controller:
// NIC register map, status flag position, FSM and grant encodings.
package cardinal_nic_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int STATUS_BIT = 63;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_TX_POLL    = 4'd1,
    ST_TX_CHECK   = 4'd2,
    ST_TX_WRITE   = 4'd3,
    ST_RX_POLL    = 4'd4,
    ST_RX_CHECK   = 4'd5,
    ST_RX_READ    = 4'd6,
    ST_RX_CAPTURE = 4'd7,
    ST_BACKOFF    = 4'd8
  } state_e;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_e;

endpackage

// File: rtl/cardinal_nic_rr_arb.sv
// Two-requester round-robin arbiter for the single NIC register port.
// Grants are only issued while arb_en_i is high; any issued grant, whether
// or not the following poll succeeds, moves the priority to the other side.
module cardinal_nic_rr_arb
  import cardinal_nic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic tx_req_i,
  input  logic rx_req_i,
  output logic gnt_tx_o,
  output logic gnt_rx_o
);

  grant_e last_q, last_d;

  // Pick a winner: on a tie the side that did not win last time goes next.
  always_comb begin
    gnt_tx_o = 1'b0;
    gnt_rx_o = 1'b0;
    if (arb_en_i) begin
      if (tx_req_i && rx_req_i) begin
        gnt_tx_o = (last_q == GRANT_RX);
        gnt_rx_o = (last_q == GRANT_TX);
      end else begin
        gnt_tx_o = tx_req_i;
        gnt_rx_o = rx_req_i;
      end
    end
    last_d = last_q;
    if (gnt_tx_o) begin
      last_d = GRANT_TX;
    end else if (gnt_rx_o) begin
      last_d = GRANT_RX;
    end
  end

  // Remember the last winner; RX after reset so TX wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GRANT_RX;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cardinal_nic_ctrl.sv
// Processor-side sequencer for the cardinal NIC register port. Turns a TX
// valid/ready stream and an RX valid/ready stream into poll/write/read
// sequences on the 2-bit NIC register port, sharing it round-robin.
module cardinal_nic_ctrl
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int POLL_GAP = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [1:0]        nic_addr,
  output logic [DATA_W-1:0] nic_d_in,
  output logic              nic_en,
  output logic              nic_en_wr,
  input  logic [DATA_W-1:0] nic_d_out,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt
);

  // The full flag is the MSB of the status word.
  localparam int SB    = (DATA_W == 64) ? STATUS_BIT : DATA_W - 1;
  localparam int GAP_W = 16;
  // Backoff counts down from POLL_GAP-1 to 0, giving POLL_GAP cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  tx_cnt_q, rx_cnt_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              arb_en, gnt_tx, gnt_rx, status_full;

  assign arb_en      = (state_q == ST_IDLE);
  assign status_full = nic_d_out[SB];

  cardinal_nic_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .arb_en_i (arb_en),
    .tx_req_i (tx_valid),
    .rx_req_i (!rx_valid_q),
    .gnt_tx_o (gnt_tx),
    .gnt_rx_o (gnt_rx)
  );

  // Next-state logic: each read is followed by a non-access check/capture cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_tx) begin
          state_d = ST_TX_POLL;
        end else if (gnt_rx) begin
          state_d = ST_RX_POLL;
        end
      end
      ST_TX_POLL:  state_d = ST_TX_CHECK;
      ST_TX_CHECK: begin
        if (!status_full) begin
          state_d = ST_TX_WRITE;
        end else if (POLL_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BACKOFF;
          gap_d   = GAP_LOAD;
        end
      end
      ST_TX_WRITE: state_d = ST_IDLE;
      ST_RX_POLL:  state_d = ST_RX_CHECK;
      ST_RX_CHECK: begin
        if (status_full) begin
          state_d = ST_RX_READ;
        end else if (POLL_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BACKOFF;
          gap_d   = GAP_LOAD;
        end
      end
      ST_RX_READ:    state_d = ST_RX_CAPTURE;
      ST_RX_CAPTURE: state_d = ST_IDLE;
      ST_BACKOFF: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode of the NIC port and tx_ready from the current state.
  always_comb begin
    nic_en    = 1'b0;
    nic_en_wr = 1'b0;
    nic_addr  = ADDR_IN_BUF;
    nic_d_in  = '0;
    tx_ready  = 1'b0;
    case (state_q)
      ST_TX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_OUT_STAT;
      end
      ST_TX_WRITE: begin
        nic_en    = 1'b1;
        nic_en_wr = 1'b1;
        nic_addr  = ADDR_OUT_BUF;
        nic_d_in  = tx_data;
        tx_ready  = 1'b1;
      end
      ST_RX_POLL: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_STAT;
      end
      ST_RX_READ: begin
        nic_en   = 1'b1;
        nic_addr = ADDR_IN_BUF;
      end
      default: begin
      end
    endcase
  end

  // State and backoff counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Delivered-packet counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (state_q == ST_TX_WRITE) begin
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
      if (state_q == ST_RX_CAPTURE) begin
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      end
    end
  end

  // RX holding register: filled on capture, drained by the consumer in any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else if (state_q == ST_RX_CAPTURE) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= nic_d_out;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign tx_cnt   = tx_cnt_q;
  assign rx_cnt   = rx_cnt_q;

endmodule
